// File: rtl/branch_resolve_unit.sv
// Branch resolution pipeline: compares operands in S1, resolves direction/target in S2,
// and reports taken/target/mispredict to fetch with a saturating mispredict counter.
module branch_resolve_unit #(
  parameter int REG_SIZE = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_op,
  input  logic [REG_SIZE-1:0] in_a,
  input  logic [REG_SIZE-1:0] in_b,
  input  logic [REG_SIZE-1:0] in_pc,
  input  logic [REG_SIZE-1:0] in_imm,
  input  logic                in_pred_taken,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_taken,
  output logic [REG_SIZE-1:0] out_target,
  output logic                out_mispredict,
  output logic                out_err,
  output logic [CNT_W-1:0]    mispredict_count
);

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLT  = 3'b010;
  localparam logic [2:0] OP_BGE  = 3'b011;
  localparam logic [2:0] OP_BLTU = 3'b100;
  localparam logic [2:0] OP_BGEU = 3'b101;
  localparam logic [2:0] OP_J    = 3'b110;

  logic                r_s1_valid;
  logic                r_s1_eq;
  logic                r_s1_lt_s;
  logic                r_s1_lt_u;
  logic                r_s1_pred;
  logic [2:0]          r_s1_op;
  logic [REG_SIZE-1:0] r_s1_seq_pc;
  logic [REG_SIZE-1:0] r_s1_br_pc;

  logic                r_s2_valid;
  logic                r_taken;
  logic                r_mispredict;
  logic                r_err;
  logic [REG_SIZE-1:0] r_target;
  logic [CNT_W-1:0]    r_count;

  logic w_s2_adv;
  logic w_in_ready;
  logic w_accept;
  logic w_out_hs;
  logic w_taken;

  assign w_s2_adv   = !r_s2_valid || out_ready;
  // in_ready is forced low during reset and flush so no request slips in
  assign w_in_ready = rst_n && !flush && (!r_s1_valid || w_s2_adv);
  assign w_accept   = in_valid && w_in_ready;
  assign w_out_hs   = r_s2_valid && out_ready;

  always_comb begin
    w_taken = 1'b0;
    case (r_s1_op)
      OP_BEQ:  w_taken = r_s1_eq;
      OP_BNE:  w_taken = !r_s1_eq;
      OP_BLT:  w_taken = r_s1_lt_s;
      OP_BGE:  w_taken = !r_s1_lt_s;
      OP_BLTU: w_taken = r_s1_lt_u;
      OP_BGEU: w_taken = !r_s1_lt_u;
      OP_J:    w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_eq     <= 1'b0;
      r_s1_lt_s   <= 1'b0;
      r_s1_lt_u   <= 1'b0;
      r_s1_pred   <= 1'b0;
      r_s1_op     <= 3'b000;
      r_s1_seq_pc <= '0;
      r_s1_br_pc  <= '0;
    end else begin
      if (flush)
        r_s1_valid <= 1'b0;
      else if (w_in_ready)
        r_s1_valid <= in_valid;
      if (w_accept) begin
        r_s1_eq     <= (in_a == in_b);
        r_s1_lt_s   <= ($signed(in_a) < $signed(in_b));
        r_s1_lt_u   <= (in_a < in_b);
        r_s1_pred   <= in_pred_taken;
        r_s1_op     <= in_op;
        r_s1_seq_pc <= in_pc + REG_SIZE'(4);
        r_s1_br_pc  <= in_pc + REG_SIZE'(4) + (in_imm << 2);
      end
    end
  end

  // Output data regs only reload when S1 actually holds an entry, so a flush or bubble keeps them stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_taken      <= 1'b0;
      r_target     <= '0;
      r_mispredict <= 1'b0;
      r_err        <= 1'b0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_taken      <= w_taken;
        r_target     <= w_taken ? r_s1_br_pc : r_s1_seq_pc;
        r_mispredict <= w_taken ^ r_s1_pred;
        r_err        <= (r_s1_op == 3'b111);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (w_out_hs && r_mispredict && !(&r_count))
      r_count <= r_count + 1'b1;
  end

  assign in_ready         = w_in_ready;
  assign out_valid        = r_s2_valid;
  assign out_taken        = r_taken;
  assign out_target       = r_target;
  assign out_mispredict   = r_mispredict;
  assign out_err          = r_err;
  assign mispredict_count = r_count;

endmodule
